// File: rtl/luma_frac_filter_if.sv
// Row bus of the luma fractional-sample filter: one input row with tag and
// stall toward the filter, three filtered rows with tag back out of it.
interface luma_frac_filter_if #(
   parameter int NUM_OUT = 8,
   parameter int LANE_W  = 15
);
   logic                        in_valid;
   logic [8*(NUM_OUT+7)-1:0]    row_in;
   logic [7:0]                  tag_in;
   logic                        stall;
   logic                        out_valid;
   logic [7:0]                  tag_out;
   logic [NUM_OUT*LANE_W-1:0]   a_row;
   logic [NUM_OUT*LANE_W-1:0]   b_row;
   logic [NUM_OUT*LANE_W-1:0]   c_row;

   // Upstream mux / collector side
   modport master (
      output in_valid, row_in, tag_in, stall,
      input  out_valid, tag_out, a_row, b_row, c_row
   );

   // Filter side
   modport slave (
      input  in_valid, row_in, tag_in, stall,
      output out_valid, tag_out, a_row, b_row, c_row
   );
endinterface

// File: rtl/luma_frac_filter.sv
// Three-stage 8-tap HEVC luma fractional filter bank. Each input row of
// NUM_OUT+7 unsigned samples yields the quarter (a), half (b) and
// three-quarter (c) pel rows, NUM_OUT saturated signed lanes each.
// Multiplies are shift/add; the row tag rides with the data.
module luma_frac_filter #(
   parameter int NUM_OUT = 8,
   parameter int LANE_W  = 15
) (
   input logic               clock,
   input logic               reset,
   luma_frac_filter_if.slave bus
);
   localparam int DATA_W = 8;
   localparam int TAG_W  = 8;
   localparam int TAPS   = 8;
   localparam int PAIRS  = TAPS / 2;
   localparam int PHASES = 3;
   localparam int NUM_IN = NUM_OUT + TAPS - 1;
   localparam int SUM_W  = 17;

   // Rows: phase a, b, c; columns: tap 0..7
   localparam int COEF [PHASES][TAPS] = '{
      '{-1, 4, -10, 58, 17,  -5, 1,  0},
      '{-1, 4, -11, 40, 40, -11, 4, -1},
      '{ 0, 1,  -5, 17, 58, -10, 4, -1}
   };

   localparam logic signed [SUM_W-1:0] SAT_HI = SUM_W'((1 <<< (LANE_W-1)) - 1);
   localparam logic signed [SUM_W-1:0] SAT_LO = SUM_W'(-(1 <<< (LANE_W-1)));

   // Constant-coefficient product built from shifts and adds only.
   function automatic logic signed [SUM_W-1:0] mul_coef(
      input logic [DATA_W-1:0] s,
      input int                c
   );
      logic signed [SUM_W-1:0] x;
      logic signed [SUM_W-1:0] m;
      x = signed'({{(SUM_W-DATA_W){1'b0}}, s});
      case ((c < 0) ? -c : c)
         0:       m = '0;
         1:       m = x;
         4:       m = x <<< 2;
         5:       m = (x <<< 2) + x;
         10:      m = (x <<< 3) + (x <<< 1);
         11:      m = (x <<< 3) + (x <<< 1) + x;
         17:      m = (x <<< 4) + x;
         40:      m = (x <<< 5) + (x <<< 3);
         58:      m = (x <<< 6) - (x <<< 2) - (x <<< 1);
         default: m = '0;
      endcase
      return (c < 0) ? -m : m;
   endfunction

   // Clamp a full-width sum into the signed lane range.
   function automatic logic signed [LANE_W-1:0] sat_lane(
      input logic signed [SUM_W-1:0] v
   );
      if (v > SAT_HI)
         return SAT_HI[LANE_W-1:0];
      else if (v < SAT_LO)
         return SAT_LO[LANE_W-1:0];
      else
         return v[LANE_W-1:0];
   endfunction

   logic                          vld_p0, vld_p1, vld_p2;
   logic [DATA_W*NUM_IN-1:0]      row_p0;
   logic [TAG_W-1:0]              tag_p0, tag_p1, tag_p2;
   logic signed [SUM_W-1:0]       part_nxt [PHASES][NUM_OUT][PAIRS];
   logic signed [SUM_W-1:0]       part_p1  [PHASES][NUM_OUT][PAIRS];
   logic signed [SUM_W-1:0]       lane_sum;
   logic [NUM_OUT*LANE_W-1:0]     row_nxt  [PHASES];
   logic [NUM_OUT*LANE_W-1:0]     row_p2   [PHASES];

   // S1: capture the incoming row and its tag
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         vld_p0 <= 1'b0;
         row_p0 <= '0;
         tag_p0 <= '0;
      end else if (!bus.stall) begin
         vld_p0 <= bus.in_valid;
         if (bus.in_valid) begin
            row_p0 <= bus.row_in;
            tag_p0 <= bus.tag_in;
         end
      end
   end

   // Pairwise tap products: taps (0,1), (2,3), (4,5), (6,7) per lane and phase
   always_comb begin
      for (int p = 0; p < PHASES; p++) begin
         for (int i = 0; i < NUM_OUT; i++) begin
            for (int k = 0; k < PAIRS; k++) begin
               part_nxt[p][i][k] =
                  mul_coef(row_p0[DATA_W*(i+2*k)   +: DATA_W], COEF[p][2*k]) +
                  mul_coef(row_p0[DATA_W*(i+2*k+1) +: DATA_W], COEF[p][2*k+1]);
            end
         end
      end
   end

   // S2: register the partial sums
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         vld_p1 <= 1'b0;
         tag_p1 <= '0;
         for (int p = 0; p < PHASES; p++)
            for (int i = 0; i < NUM_OUT; i++)
               for (int k = 0; k < PAIRS; k++)
                  part_p1[p][i][k] <= '0;
      end else if (!bus.stall) begin
         vld_p1 <= vld_p0;
         if (vld_p0) begin
            tag_p1  <= tag_p0;
            part_p1 <= part_nxt;
         end
      end
   end

   // Final four-term sum and saturation, packed into output rows
   always_comb begin
      lane_sum = '0;
      for (int p = 0; p < PHASES; p++) begin
         row_nxt[p] = '0;
         for (int i = 0; i < NUM_OUT; i++) begin
            lane_sum = part_p1[p][i][0] + part_p1[p][i][1] +
                       part_p1[p][i][2] + part_p1[p][i][3];
            row_nxt[p][LANE_W*i +: LANE_W] = sat_lane(lane_sum);
         end
      end
   end

   // S3: output registers, held while no new result arrives
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         vld_p2 <= 1'b0;
         tag_p2 <= '0;
         for (int p = 0; p < PHASES; p++)
            row_p2[p] <= '0;
      end else if (!bus.stall) begin
         vld_p2 <= vld_p1;
         if (vld_p1) begin
            tag_p2 <= tag_p1;
            row_p2 <= row_nxt;
         end
      end
   end

   assign bus.out_valid = vld_p2;
   assign bus.tag_out   = tag_p2;
   assign bus.a_row     = row_p2[0];
   assign bus.b_row     = row_p2[1];
   assign bus.c_row     = row_p2[2];

endmodule

// File: doc/luma_frac_filter.md
# luma_frac_filter

Pipelined 8-tap HEVC luma fractional-sample filter bank that sits directly downstream of the input-row mux. It consumes one 120-bit row (15 unsigned 8-bit integer samples) per cycle and produces the three horizontal fractional rows (quarter "a", half "b", three-quarter "c"), each 8 signed 15-bit lanes. These rows are the words later packed into the a/b/c half arrays. The row tag travels alongside the data, so the downstream collector knows which mux selection each result belongs to.

## Interface

Parameters
- `NUM_OUT`, 8: output lanes per row. Fixed; the input row holds `NUM_OUT+7` samples.
- `LANE_W`, 15: output lane width in bits (signed).

Ports
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  `row_in`/`tag_in` carry a row this cycle.
- `row_in`  in  120  sample k = `row_in[8k+7:8k]`, k=0..14, unsigned.
- `tag_in`  in  8  selection tag (the mux `sel` value) for this row.
- `stall`  in  1  freezes the entire pipeline, including valids.
- `out_valid`  out  1  `a_row`/`b_row`/`c_row`/`tag_out` hold a new result.
- `tag_out`  out  8  tag of the emitted row.
- `a_row`  out  120  lane i = `a_row[15i+14:15i]`, quarter-pel result.
- `b_row`  out  120  half-pel result, same lane layout.
- `c_row`  out  120  three-quarter-pel result, same lane layout.

## Operation

- Lane i (0..7) = sat15( Σ_{j=0..7} coef[j]·sample[i+j] ).
- Coefficients (j = 0..7):
  - a: −1, 4, −10, 58, 17, −5, 1, 0
  - b: −1, 4, −11, 40, 40, −11, 4, −1
  - c: 0, 1, −5, 17, 58, −10, 4, −1
- Implement multiplies as shift/add only; no multiplier instances.
- Internal sums are at least 17 bits signed. No rounding and no shift.
- sat15 clamps to [−16384, 16383]. Outputs are two's complement, 15 bits.
- Negative saturation cannot occur for 8-bit input, but it is implemented anyway.
- Pipeline stages:
  - S1: register `row_in`, `tag_in`, `in_valid`.
  - S2: pairwise partial sums, 4 per lane per phase.
  - S3: final sum, saturate, register into the outputs.
- Each stage has a valid bit. Valid bits shift forward every cycle that `stall`=0.
- Stage data/tag registers load only when their incoming valid is 1 and `stall`=0. Otherwise they hold their value.
- Outputs therefore keep the last valid result while `out_valid`=0.
- `stall`=1 holds every register, valid bits included. Inputs presented during a stall are dropped; upstream must not assert `in_valid` while stalling.
- No internal flow control beyond `stall`. Throughput is one row per cycle.

## Timing

- Reset (async, immediate): all valid bits 0; `out_valid`=0; `tag_out`=0; `a_row`=`b_row`=`c_row`=0; all internal data registers 0.
- Reset deassertion: the first capture happens on the first rising edge with `reset`=0.
- Latency: a row sampled with `in_valid`=1 at edge N appears with `out_valid`=1 after edge N+2. That is 3 register stages, visible in the cycle following edge N+2.
- Back-to-back valid rows emerge on consecutive cycles in input order.
- Bubbles (`in_valid`=0) produce `out_valid`=0 cycles at the same position in the stream.
- Each stall cycle adds exactly one cycle of latency to every in-flight row. Nothing is lost or duplicated.
- `out_valid` stays at its pre-stall value during a stall.
- Reset mid-stream: all in-flight rows are discarded. Nothing is emitted afterwards until new valid input has passed through 3 stages.
- `stall` and `reset` together: reset wins.

## Test plan

- Flat input: all 15 samples = 100, `tag_in`=0x05. Required response: every lane of a/b/c = 6400 (0x1900), `tag_out`=0x05, exactly 3 cycles after input.
- Impulse: sample[3]=1, all others 0.
  - Lane 0: a=58, b=40, c=17.
  - Lane 1: a=−10 (0x7FF6), b=−11 (0x7FF5), c=−5 (0x7FFB).
  - Lanes 4..7 = 0.
- Saturation: samples 1, 3, 4, 6 = 255, others 0. Required response: lane 0 of a, b and c = 16383 (0x3FFF), since raw sums 20400, 22440 and 20400 are clamped.
- Streaming with bubbles: tags 1, 2, -, 3 (a gap after tag 2) on 4 consecutive cycles. Required response: `out_valid` pattern 1,1,0,1 in the same order; outputs hold the tag-2 data through the bubble cycle.
- Stall: 3 rows in flight, then `stall`=1 for 2 cycles. Required response: outputs and `out_valid` frozen during the stall; afterwards all 3 rows emitted in order, each delayed 2 cycles.
- Async reset mid-stream: assert `reset` between edges with 2 rows in flight. Required response: outputs go to 0 immediately, and no `out_valid` follows until new input is applied.
